mipi_csi_tx_packet_encoder_8b2lane: RTL and testbench

MIPI_CSI_TX_PACKET_ENCODER_8B2LANE -- requirements
Module: mipi_csi_tx_packet_encoder_8b2lane

---
 rtl/mipi_csi_tx_packet_encoder_8b2lane.sv | 214 +++++++++++++++++++++
 tb/tb_mipi_csi_tx_packet_encoder_8b2lane.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_tx_packet_encoder_8b2lane.sv
// ---------------------------------------------------------------------------
// mipi_csi_tx_packet_encoder_8b2lane
//
// Builds MIPI CSI-2 packets for a two-lane, 8-bit-per-lane byte interface.
// Each accepted request emits a sync word, a two-cycle packet header with
// Hamming ECC, an optional payload streamed from data_i, a 16-bit footer on
// long packets, and one idle gap cycle. All outputs are registered.
//
// Optional feature: define MIPI_CSI_TX_CRC_EN to build the CRC-16 footer
// generator. Without it the footer is sent as 0x0000 with identical timing.
//
// Ports
//   clk_i              byte clock, rising edge
//   reset_n_i          asynchronous active-low reset
//   packet_start_i     one-cycle request, taken only while idle
//   packet_type_i[5:0] CSI-2 data type (0x00-0x0F short, else long)
//   virtual_channel_i  virtual channel
//   packet_length_i    long: word count in bytes (must be even); short: data
//   data_i[15:0]       payload beat, [7:0] lane 0 (earlier byte), [15:8] lane 1
//   data_ready_o       data_i is consumed this cycle
//   data_o[15:0]       lane bytes, [7:0] lane 0, [15:8] lane 1
//   output_valid_o     data_o carries a burst byte pair
//   busy_o             packet in progress (acceptance through gap)
//   error_o            one-cycle pulse for a rejected request
// ---------------------------------------------------------------------------
module mipi_csi_tx_packet_encoder_8b2lane (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        packet_start_i,
  input  logic [5:0]  packet_type_i,
  input  logic [1:0]  virtual_channel_i,
  input  logic [15:0] packet_length_i,
  input  logic [15:0] data_i,
  output logic        data_ready_o,
  output logic [15:0] data_o,
  output logic        output_valid_o,
  output logic        busy_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    IDLE, SYNC, HDR0, HDR1, PAYLOAD, FOOT, GAP
  } state_t;

  state_t      state;
  state_t      nxt_state;

  // Packet fields captured at acceptance.
  logic [5:0]  dt;
  logic [1:0]  vc;
  logic [15:0] wc;
  logic [14:0] cnt;

  logic        long_pkt;
  logic        req_long;
  logic        accept;
  logic        consume;
  logic [7:0]  data_id;
  logic [7:0]  ecc;
  logic [15:0] footer;

  logic [15:0] nxt_data;
  logic        nxt_valid;
  logic        nxt_ready;
  logic        nxt_busy;
  logic        nxt_error;

  // Each ECC parity bit is the XOR of the header bits selected by its mask;
  // header bit order is {WC msb, WC lsb, DataID}.
  function automatic logic [7:0] ecc_calc(input logic [23:0] h);
    ecc_calc = {2'b00,
                ^(h & 24'hEFFC00),
                ^(h & 24'hDF03F0),
                ^(h & 24'hB8E38E),
                ^(h & 24'h749A6D),
                ^(h & 24'hF2555B),
                ^(h & 24'hF12CB7)};
  endfunction

  assign long_pkt = |dt[5:4];
  assign req_long = |packet_type_i[5:4];
  assign data_id  = {vc, dt};
  assign ecc      = ecc_calc({wc, data_id});
  // The registered ready flag marks exactly the cycles in which data_i is taken.
  assign consume  = data_ready_o;

`ifdef MIPI_CSI_TX_CRC_EN
  logic [15:0] crc;

  // Reflected CCITT polynomial, LSB first. Bits 0..7 are the lane-0 byte and
  // bits 8..15 the lane-1 byte, so walking the word from bit 0 upward gives
  // the required lane-0-then-lane-1 order in one cycle.
  function automatic logic [15:0] crc_pair(input logic [15:0] c,
                                           input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 16; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   crc <= 16'hFFFF;
    else if (accept)  crc <= 16'hFFFF;
    else if (consume) crc <= crc_pair(crc, data_i);
  end

  assign footer = crc;
`else
  assign footer = 16'h0000;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    nxt_data  = 16'h0000;
    nxt_valid = 1'b0;
    nxt_ready = 1'b0;
    nxt_busy  = 1'b1;
    nxt_error = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        nxt_busy = 1'b0;
        if (packet_start_i) begin
          if (!req_long || !packet_length_i[0]) begin
            accept    = 1'b1;
            nxt_state = SYNC;
            nxt_data  = 16'hB8B8;
            nxt_valid = 1'b1;
            nxt_busy  = 1'b1;
          end else begin
            nxt_error = 1'b1;
          end
        end
      end
      SYNC: begin
        nxt_state = HDR0;
        nxt_data  = {wc[7:0], data_id};
        nxt_valid = 1'b1;
      end
      HDR0: begin
        nxt_state = HDR1;
        nxt_data  = {ecc, wc[15:8]};
        nxt_valid = 1'b1;
        // Ready rises together with HDR1 so the first beat lands right after it.
        nxt_ready = long_pkt && (cnt != 15'd0);
      end
      HDR1, PAYLOAD: begin
        nxt_valid = 1'b1;
        if (consume) begin
          nxt_state = PAYLOAD;
          nxt_data  = data_i;
          nxt_ready = (cnt != 15'd1);
        end else if (long_pkt) begin
          nxt_state = FOOT;
          nxt_data  = footer;
        end else begin
          nxt_state = GAP;
          nxt_valid = 1'b0;
        end
      end
      FOOT: begin
        nxt_state = GAP;
      end
      GAP: begin
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
      end
    endcase
  end

  // Output stage and packet field capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o         <= 16'h0000;
      output_valid_o <= 1'b0;
      data_ready_o   <= 1'b0;
      busy_o         <= 1'b0;
      error_o        <= 1'b0;
      dt             <= 6'd0;
      vc             <= 2'd0;
      wc             <= 16'd0;
      cnt            <= 15'd0;
    end else begin
      data_o         <= nxt_data;
      output_valid_o <= nxt_valid;
      data_ready_o   <= nxt_ready;
      busy_o         <= nxt_busy;
      error_o        <= nxt_error;
      if (accept) begin
        dt  <= packet_type_i;
        vc  <= virtual_channel_i;
        wc  <= packet_length_i;
        cnt <= packet_length_i[15:1];
      end else if (consume) begin
        cnt <= cnt - 15'd1;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi_tx_packet_encoder_8b2lane.sv
// ---------------------------------------------------------------------------
// tb_mipi_csi_tx_packet_encoder_8b2lane
//
// Directed and randomized packets are driven into the encoder; the expected
// per-cycle output stream of each packet is built from the packet fields
// (sync word, header with ECC, payload, footer) and compared cycle by cycle.
// Honors MIPI_CSI_TX_CRC_EN for the expected footer.
// ---------------------------------------------------------------------------
module tb_mipi_csi_tx_packet_encoder_8b2lane;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        packet_start_i;
  logic [5:0]  packet_type_i;
  logic [1:0]  virtual_channel_i;
  logic [15:0] packet_length_i;
  logic [15:0] data_i;
  logic        data_ready_o;
  logic [15:0] data_o;
  logic        output_valid_o;
  logic        busy_o;
  logic        error_o;

  int vectors = 0;
  int miscompares = 0;
  int cur_t = 0;

  logic [7:0] pay[$];

  // ECC contribution of each header bit (bit 0 = DataID bit 0).
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  localparam logic [7:0] FIXED_PAY [24] = '{
    8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
    8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
    8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  mipi_csi_tx_packet_encoder_8b2lane dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .packet_start_i    (packet_start_i),
    .packet_type_i     (packet_type_i),
    .virtual_channel_i (virtual_channel_i),
    .packet_length_i   (packet_length_i),
    .data_i            (data_i),
    .data_ready_o      (data_ready_o),
    .data_o            (data_o),
    .output_valid_o    (output_valid_o),
    .busy_o            (busy_o),
    .error_o           (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, cur_t, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_ecc(input logic [23:0] h);
    logic [5:0] e;
    e = 6'd0;
    for (int i = 0; i < 24; i++)
      if (h[i]) e = e ^ ECC_COL[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pay[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    return c;
  endfunction

  task automatic fill_random(input int beats);
    pay.delete();
    for (int i = 0; i < 2 * beats; i++) pay.push_back(8'($urandom));
  endtask

  // Sends one packet and checks every cycle from N+1 until the encoder is
  // idle again. inject_t pulses a second legal request at that cycle;
  // abort_t applies reset at that cycle and ends the packet early.
  // fixed_foot >= 0 replaces the modelled footer with a known constant.
  task automatic run_packet(input logic [5:0] typ, input logic [1:0] ch,
                            input logic [15:0] len, input int inject_t,
                            input int abort_t, input int fixed_foot);
    logic [15:0] exp_q[$];
    logic [15:0] foot;
    logic        is_long;
    int          beats, n, bi, rdy;
    is_long = (typ >= 6'h10);
    beats   = is_long ? int'(len) / 2 : 0;
    exp_q.push_back(16'hB8B8);
    exp_q.push_back({len[7:0], ch, typ});
    exp_q.push_back({model_ecc({len, ch, typ}), len[15:8]});
    for (int j = 0; j < beats; j++) exp_q.push_back({pay[2*j+1], pay[2*j]});
    if (is_long) begin
`ifdef MIPI_CSI_TX_CRC_EN
      foot = model_crc();
`else
      foot = 16'h0000;
`endif
      if (fixed_foot >= 0) foot = 16'(fixed_foot);
      exp_q.push_back(foot);
    end
    n = exp_q.size();
    cur_t = 0;
    check("busy_before_start", busy_o, 0);
    packet_start_i    = 1'b1;
    packet_type_i     = typ;
    virtual_channel_i = ch;
    packet_length_i   = len;
    step();
    packet_start_i    = 1'b0;
    packet_type_i     = 6'($urandom);
    virtual_channel_i = 2'($urandom);
    packet_length_i   = 16'($urandom);
    bi  = 0;
    rdy = 0;
    for (int t = 1; t <= n + 2; t++) begin
      cur_t = t;
      check("valid", output_valid_o, (t <= n));
      if (t <= n) check("data", data_o, exp_q[t-1]);
      else        check("data_idle", data_o, 0);
      check("busy", busy_o, (t <= n + 1));
      check("ready", data_ready_o, (is_long && t >= 3 && t < 3 + beats));
      check("error", error_o, 0);
      if (t == abort_t) begin
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_data", data_o, 0);
        check("rst_valid", output_valid_o, 0);
        check("rst_ready", data_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_error", error_o, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("rst_hold_valid", output_valid_o, 0);
        reset_n_i = 1'b1;
        step();
        return;
      end
      if (data_ready_o) begin
        rdy++;
        if (bi < beats) data_i = {pay[2*bi+1], pay[2*bi]};
        else            data_i = 16'($urandom);
        bi++;
      end else begin
        data_i = 16'($urandom);
      end
      if (t == inject_t) begin
        packet_start_i    = 1'b1;
        packet_type_i     = 6'h12;
        packet_length_i   = 16'h0040;
      end else begin
        packet_start_i    = 1'b0;
      end
      step();
    end
    check("ready_cycles", rdy, beats);
  endtask

  initial begin
    logic [5:0]  typ;
    logic [15:0] len;
    int          ff;
    reset_n_i         = 1'b0;
    packet_start_i    = 1'b0;
    packet_type_i     = 6'd0;
    virtual_channel_i = 2'd0;
    packet_length_i   = 16'd0;
    data_i            = 16'd0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_data", data_o, 0);
    check("reset_valid", output_valid_o, 0);
    check("reset_ready", data_ready_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_error", error_o, 0);
    reset_n_i = 1'b1;
    step();

    // Short packet, all-zero header.
    pay.delete();
    run_packet(6'h00, 2'd0, 16'h0000, 0, 0, -1);

    // Reference long packet with known CRC.
    pay.delete();
    foreach (FIXED_PAY[i]) pay.push_back(FIXED_PAY[i]);
`ifdef MIPI_CSI_TX_CRC_EN
    ff = 16'h00F0;
`else
    ff = 0;
`endif
    run_packet(6'h2B, 2'd0, 16'd24, 0, 0, ff);

    // Long packet with empty payload: footer is the CRC seed.
    pay.delete();
`ifdef MIPI_CSI_TX_CRC_EN
    ff = 16'hFFFF;
`else
    ff = 0;
`endif
    run_packet(6'h2B, 2'd3, 16'd0, 0, 0, ff);

    // Odd long length is rejected, then a legal request is taken.
    cur_t = 0;
    packet_start_i  = 1'b1;
    packet_type_i   = 6'h2C;
    packet_length_i = 16'd5;
    step();
    packet_start_i  = 1'b0;
    cur_t = 1;
    check("rej_error", error_o, 1);
    check("rej_valid", output_valid_o, 0);
    check("rej_busy", busy_o, 0);
    check("rej_data", data_o, 0);
    step();
    cur_t = 2;
    check("rej_error_clr", error_o, 0);
    check("rej_valid2", output_valid_o, 0);
    fill_random(3);
    run_packet(6'h2C, 2'd1, 16'd6, 0, 0, -1);

    // Request during payload is ignored.
    fill_random(8);
    run_packet(6'h2B, 2'd1, 16'd16, 6, 0, -1);

    // Reset in the third payload cycle, then a fresh packet.
    fill_random(4);
    run_packet(6'h2A, 2'd2, 16'd8, 0, 6, -1);
    fill_random(2);
    run_packet(6'h2A, 2'd0, 16'd4, 0, 0, -1);

    // Randomized mix of short and long packets, some back to back.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        typ = 6'($urandom_range(0, 15));
        len = 16'($urandom);
        pay.delete();
      end else begin
        typ = 6'($urandom_range(16, 63));
        len = 16'($urandom_range(0, 24) * 2);
        fill_random(int'(len) / 2);
      end
      run_packet(typ, 2'($urandom), len, 0, 0, -1);
      repeat ($urandom_range(0, 2)) step();
    end

    // Largest legal word count: counter must not wrap.
    fill_random(32767);
    run_packet(6'h2B, 2'd2, 16'hFFFE, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
